// File: rtl/conv_mac_5x7_pkg.sv
// conv_mac_5x7_pkg: constants and types shared by the 5x7 convolution MAC
// and the 45-bit result FIFO it feeds.
//   PX_W / WT_W : signed pixel / weight widths
//   ACC_W       : accumulator and FIFO data width
//   TAPS        : taps per window (5x7, row-major)
//   TAP_W       : width of the tap index
package conv_mac_5x7_pkg;
  localparam int PX_W   = 18;
  localparam int WT_W   = 18;
  localparam int ACC_W  = 45;
  localparam int TAPS   = 35;
  localparam int TAP_W  = 6;
  localparam int PROD_W = PX_W + WT_W;

  localparam logic [TAP_W-1:0] TAP_CNT  = 6'd35;
  localparam logic [TAP_W-1:0] LAST_TAP = 6'd34;

  // Window position tags that travel down the pipeline beside the data.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tap_tag_t;

  // Sign-extend a product to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction
endpackage

// File: rtl/conv_mac_5x7_mul_pipe.sv
// conv_mac_5x7_mul_pipe: registered signed multiplier stage (S1 -> S2).
//   clk, reset : clock and asynchronous active-low reset
//   en_i       : stall; low holds every register
//   tag_i      : S1 window tags (valid/first/last)
//   px_i, wt_i : S1 signed pixel and weight
//   tag_o      : S2 window tags
//   prod_o     : S2 signed product, PX_W+WT_W bits
module conv_mac_5x7_mul_pipe
  import conv_mac_5x7_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  tap_tag_t                 tag_i,
  input  logic signed [PX_W-1:0]   px_i,
  input  logic signed [WT_W-1:0]   wt_i,
  output tap_tag_t                 tag_o,
  output logic signed [PROD_W-1:0] prod_o
);

  tap_tag_t                 tag_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_d;

  // Full-width signed product; operands are sign-extended before multiplying.
  always_comb begin
    prod_d = PROD_W'(px_i) * PROD_W'(wt_i);
  end

  // S2 registers; the product only loads when a valid tap is present.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= tap_tag_t'(3'b000);
      prod_q <= {PROD_W{1'b0}};
    end else if (en_i) begin
      tag_q <= tag_i;
      if (tag_i.valid) begin
        prod_q <= prod_d;
      end
    end
  end

  assign tag_o  = tag_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/conv_mac_5x7.sv
// conv_mac_5x7: 5x7 convolution multiply-accumulate feeding a result FIFO.
//   clk, reset          : clock and asynchronous active-low reset
//   enable              : global stall; low freezes all state except weight loads
//   wt_load/addr/data   : weight register file write port (idle only)
//   px_valid/data/last  : pixel stream, px_last marks tap 34 (checked only)
//   px_ready            : pixel accepted when px_valid && px_ready
//   fifo_full           : downstream FIFO full flag
//   fifo_write/data     : result push to the FIFO
//   busy                : window in progress or result pending
//   err                 : sticky protocol error
module conv_mac_5x7
  import conv_mac_5x7_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wt_load,
  input  logic [TAP_W-1:0]        wt_addr,
  input  logic signed [WT_W-1:0]  wt_data,
  input  logic                    px_valid,
  input  logic signed [PX_W-1:0]  px_data,
  input  logic                    px_last,
  output logic                    px_ready,
  input  logic                    fifo_full,
  output logic                    fifo_write,
  output logic signed [ACC_W-1:0] fifo_data,
  output logic                    busy,
  output logic                    err
);

  logic [TAP_W-1:0]         tap_q, tap_d;
  logic signed [WT_W-1:0]   wt_q [TAPS];
  tap_tag_t                 s1_tag_q;
  logic signed [PX_W-1:0]   s1_px_q;
  logic signed [WT_W-1:0]   s1_wt_q;
  tap_tag_t                 s2_tag_s;
  logic signed [PROD_W-1:0] s2_prod_s;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  fifo_data_q;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q;

  logic                     px_ready_s, accept_s, fifo_write_s, busy_s;
  logic                     wt_we_s, wt_err_s, is_last_tap_s, last_err_s;
  logic signed [ACC_W-1:0]  prod_ext_s;

  // Handshake, error detection and next-state for counter, accumulator, output.
  always_comb begin
    px_ready_s    = reset & enable & ~(out_valid_q & fifo_full);
    accept_s      = px_valid & px_ready_s;
    fifo_write_s  = reset & enable & out_valid_q & ~fifo_full;
    busy_s        = (tap_q != {TAP_W{1'b0}}) | s1_tag_q.valid | s2_tag_s.valid | out_valid_q;
    // busy_s reflects state before the edge, so a load alongside the first
    // accept of a window still lands; S1 already sampled the old weight.
    wt_we_s       = wt_load & ~busy_s & (wt_addr < TAP_CNT);
    wt_err_s      = wt_load & (busy_s | (wt_addr >= TAP_CNT));
    is_last_tap_s = (tap_q == LAST_TAP);
    last_err_s    = accept_s & (px_last ^ is_last_tap_s);
    tap_d         = accept_s ? (is_last_tap_s ? 6'd0 : tap_q + 6'd1) : tap_q;
    prod_ext_s    = sext_prod(s2_prod_s);
    acc_d         = s2_tag_s.first ? prod_ext_s : acc_q + prod_ext_s;
    // A new result cannot meet a pending one: a window needs 35 accepts.
    out_valid_d   = (s2_tag_s.valid & s2_tag_s.last) ? 1'b1 :
                    (fifo_write_s ? 1'b0 : out_valid_q);
  end

  // Weight register file: no reset so coefficients survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (wt_we_s) begin
      wt_q[wt_addr] <= wt_data;
    end
  end

  // Tap counter, S1 capture, S3 accumulate, output register and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q       <= 6'd0;
      s1_tag_q    <= tap_tag_t'(3'b000);
      s1_px_q     <= {PX_W{1'b0}};
      s1_wt_q     <= {WT_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      fifo_data_q <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Weight-load errors are flagged even while stalled.
      err_q <= err_q | wt_err_s | last_err_s;
      if (enable) begin
        tap_q          <= tap_d;
        s1_tag_q.valid <= accept_s;
        s1_tag_q.first <= (tap_q == 6'd0);
        s1_tag_q.last  <= is_last_tap_s;
        if (accept_s) begin
          s1_px_q <= px_data;
          s1_wt_q <= wt_q[tap_q];
        end
        if (s2_tag_s.valid) begin
          acc_q <= acc_d;
          if (s2_tag_s.last) begin
            fifo_data_q <= acc_d;
          end
        end
        out_valid_q <= out_valid_d;
      end
    end
  end

  conv_mac_5x7_mul_pipe u_mul (
    .clk    (clk),
    .reset  (reset),
    .en_i   (enable),
    .tag_i  (s1_tag_q),
    .px_i   (s1_px_q),
    .wt_i   (s1_wt_q),
    .tag_o  (s2_tag_s),
    .prod_o (s2_prod_s)
  );

  assign px_ready   = px_ready_s;
  assign fifo_write = fifo_write_s;
  assign fifo_data  = fifo_data_q;
  assign busy       = busy_s;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_mac_5x7.sv
// tb_conv_mac_5x7: self-checking bench for conv_mac_5x7. A dot-product model
// over bench-held weight and pixel arrays predicts every FIFO result.
module tb_conv_mac_5x7;
  logic clk = 1'b0;
  logic reset, enable, wt_load;
  logic [5:0] wt_addr;
  logic signed [17:0] wt_data;
  logic px_valid;
  logic signed [17:0] px_data;
  logic px_last, px_ready, fifo_full, fifo_write;
  logic signed [44:0] fifo_data;
  logic busy, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_wt[35];
  int cur_px[35];
  logic [44:0] wr_q[$];
  int wr_cyc_q[$];

  conv_mac_5x7 dut (
    .clk(clk), .reset(reset), .enable(enable), .wt_load(wt_load),
    .wt_addr(wt_addr), .wt_data(wt_data), .px_valid(px_valid),
    .px_data(px_data), .px_last(px_last), .px_ready(px_ready),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write the FIFO would accept, with its cycle stamp.
  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      wr_q.push_back(fifo_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < 35; i++) s += longint'(cur_px[i]) * longint'(model_wt[i]);
    return s;
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  task automatic clear_writes();
    wr_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 35; i++) begin
      wt_load = 1'b1; wt_addr = 6'(i); wt_data = 18'(model_wt[i]);
      @(posedge clk); #1;
    end
    wt_load = 1'b0;
  endtask

  task automatic push_px(input int d, input bit last, output int acc_cyc);
    int guard;
    guard = 0;
    px_valid = 1'b1; px_data = 18'(d); px_last = last;
    @(negedge clk);
    while (px_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (px_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: px_ready=%b required 1", px_ready);
    end
    @(posedge clk); #1;
    px_valid = 1'b0; px_last = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic send_window(input int bad_idx, output int last_cyc);
    for (int i = 0; i < 35; i++) push_px(cur_px[i], (i == 34) != (i == bad_idx), last_cyc);
  endtask

  task automatic wait_write(input int budget, output bit got, output logic [44:0] d, output int c);
    got = 1'b0; d = 45'd0; c = 0;
    for (int i = 0; i < budget && wr_q.size() == 0; i++) @(posedge clk);
    @(posedge clk); #1;
    if (wr_q.size() != 0) begin
      got = 1'b1;
      d = wr_q.pop_front();
      c = wr_cyc_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; wt_load = 1'b0; wt_addr = 6'd0; wt_data = 18'd0;
    px_valid = 1'b0; px_data = 18'd0; px_last = 1'b0; fifo_full = 1'b0;
    #12;
    checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL rst_px_ready: got %b want 0", px_ready); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL rst_fifo_write: got %b want 0", fifo_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (fifo_data !== 45'd0) begin errors++; $display("FAIL rst_fifo_data: got %0d want 0", fifo_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL idle_px_ready: got %b want 1", px_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_unit_weights();
    bit got; logic [44:0] d; int c, lc; longint e;
    for (int i = 0; i < 35; i++) begin model_wt[i] = 1; cur_px[i] = i + 1; end
    load_weights();
    clear_writes();
    send_window(-1, lc);
    wait_write(20, got, d, c);
    e = model_sum();
    checks++; if (!got) begin errors++; $display("FAIL unit_write: got none want 1"); end
    checks++; if (d !== e[44:0]) begin errors++; $display("FAIL unit_sum: got %0d want %0d", $signed(d), e); end
    checks++; if (c !== lc + 2) begin errors++; $display("FAIL unit_latency: got cyc %0d want %0d", c, lc + 2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL unit_err: got %b want 0", err); end
    repeat (5) @(posedge clk); #1;
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL unit_extra_writes: got %0d want 0", wr_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unit_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_signed_extremes();
    bit got; logic [44:0] d; int c, lc; longint e;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 35; i++) begin
        model_wt[i] = (k == 0) ? -1 : -131072;
        cur_px[i]   = (k == 0) ? 131071 : -131072;
      end
      load_weights();
      clear_writes();
      send_window(-1, lc);
      wait_write(20, got, d, c);
      e = model_sum();
      checks++; if (!got) begin errors++; $display("FAIL extreme%0d_write: got none want 1", k); end
      checks++; if (d !== e[44:0]) begin errors++; $display("FAIL extreme%0d_sum: got %0d want %0d", k, $signed(d), e); end
    end
  endtask

  task automatic test_random_windows();
    bit got; logic [44:0] d; int c, lc; longint e;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 35; i++) begin model_wt[i] = rnd18(); cur_px[i] = rnd18(); end
      load_weights();
      clear_writes();
      send_window(-1, lc);
      wait_write(20, got, d, c);
      e = model_sum();
      checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL rand%0d_sum: got %0d want %0d", k, $signed(d), e); end
      checks++; if (c !== lc + 2) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", k, c, lc + 2); end
    end
  endtask

  task automatic test_back_to_back();
    int win_px[3][35]; longint exp_sum[3]; int lc[3]; int guard;
    logic [44:0] d;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 35; i++) begin win_px[w][i] = rnd18(); cur_px[i] = win_px[w][i]; end
      exp_sum[w] = model_sum();
    end
    clear_writes();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 35; i++) cur_px[i] = win_px[w][i];
      send_window(-1, lc[w]);
    end
    guard = 0;
    while (wr_q.size() < 3 && guard < 30) begin @(posedge clk); guard++; end
    #1;
    checks++; if (wr_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", wr_q.size()); end
    for (int w = 0; w < 3 && w < wr_q.size(); w++) begin
      d = wr_q[w];
      checks++; if (d !== exp_sum[w][44:0]) begin errors++; $display("FAIL b2b_sum%0d: got %0d want %0d", w, $signed(d), exp_sum[w]); end
      checks++; if (wr_cyc_q[w] !== lc[w] + 2) begin errors++; $display("FAIL b2b_lat%0d: got %0d want %0d", w, wr_cyc_q[w], lc[w] + 2); end
      if (w > 0) begin
        checks++;
        if (wr_cyc_q[w] - wr_cyc_q[w-1] !== 35) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d want 35", w, wr_cyc_q[w] - wr_cyc_q[w-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got; logic [44:0] d; int c, lc; longint e;
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    e = model_sum();
    clear_writes();
    fifo_full = 1'b1;
    send_window(-1, lc);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL bp_px_ready%0d: got %b want 0", k, px_ready); end
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL bp_fifo_write%0d: got %b want 0", k, fifo_write); end
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    wait_write(10, got, d, c);
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL bp_sum: got %0d want %0d", $signed(d), e); end
    @(negedge clk);
    checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", px_ready); end
    repeat (5) @(posedge clk); #1;
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL bp_extra_writes: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_enable();
    bit got; logic [44:0] d; int c, lc; longint e; int nw;
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    e = model_sum();
    clear_writes();
    for (int i = 0; i < 10; i++) push_px(cur_px[i], 1'b0, lc);
    enable = 1'b0; px_valid = 1'b1; px_data = 18'sd777;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL en_px_ready%0d: got %b want 0", k, px_ready); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    enable = 1'b1; px_valid = 1'b0;
    for (int i = 10; i < 35; i++) push_px(cur_px[i], i == 34, lc);
    wait_write(20, got, d, c);
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL en_sum: got %0d want %0d", $signed(d), e); end
    // Weight load while stalled and idle must still land.
    repeat (3) @(posedge clk); #1;
    nw = rnd18();
    enable = 1'b0; wt_load = 1'b1; wt_addr = 6'd0; wt_data = 18'(nw);
    @(posedge clk); #1;
    wt_load = 1'b0; enable = 1'b1;
    model_wt[0] = nw;
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    cur_px[0] = 131071;
    e = model_sum();
    clear_writes();
    send_window(-1, lc);
    wait_write(20, got, d, c);
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL en_wtload_sum: got %0d want %0d", $signed(d), e); end
  endtask

  task automatic test_reset_mid_window();
    bit got; logic [44:0] d; int c, lc; longint e;
    wt_load = 1'b1; wt_addr = 6'd40; wt_data = 18'sd5;
    @(posedge clk); #1;
    wt_load = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL addr_err: got %b want 1", err); end
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    clear_writes();
    for (int i = 0; i < 20; i++) push_px(cur_px[i], 1'b0, lc);
    reset = 1'b0;
    #2;
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL midrst_fifo_write: got %b want 0", fifo_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
    checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL midrst_px_ready: got %b want 0", px_ready); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    e = model_sum();
    send_window(-1, lc);
    wait_write(20, got, d, c);
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL midrst_sum: got %0d want %0d", $signed(d), e); end
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL midrst_extra: got %0d want 0", wr_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err_after: got %b want 0", err); end
  endtask

  task automatic test_wt_load_busy();
    bit got; logic [44:0] d; int c, lc; longint e;
    reset_dut();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wtbusy_err_pre: got %b want 0", err); end
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    cur_px[30] = -131072;
    e = model_sum();
    clear_writes();
    for (int i = 0; i < 5; i++) push_px(cur_px[i], 1'b0, lc);
    wt_load = 1'b1; wt_addr = 6'd30; wt_data = 18'(model_wt[30] ^ 32'h155);
    @(posedge clk); #1;
    wt_load = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wtbusy_err: got %b want 1", err); end
    for (int i = 5; i < 35; i++) push_px(cur_px[i], i == 34, lc);
    wait_write(20, got, d, c);
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL wtbusy_sum: got %0d want %0d", $signed(d), e); end
  endtask

  task automatic test_px_last_err();
    bit got; logic [44:0] d; int c, lc; longint e;
    reset_dut();
    for (int i = 0; i < 35; i++) cur_px[i] = rnd18();
    e = model_sum();
    clear_writes();
    for (int i = 0; i < 10; i++) push_px(cur_px[i], 1'b0, lc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_err_pre: got %b want 0", err); end
    for (int i = 10; i < 35; i++) push_px(cur_px[i], (i == 10) || (i == 34), lc);
    wait_write(20, got, d, c);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL last_err: got %b want 1", err); end
    checks++; if (!got || d !== e[44:0]) begin errors++; $display("FAIL last_sum: got %0d want %0d", $signed(d), e); end
  endtask

  initial begin
    test_reset();
    test_unit_weights();
    test_signed_extremes();
    test_random_windows();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_mid_window();
    test_wt_load_busy();
    test_px_last_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
